// File: rtl/mag_pkg.sv
// Shared magnitude-path constants and helpers used by the estimator and the meter.
package mag_pkg;
  localparam int MAG_W = 12;

  // Block accumulator width: a full block of max-scale samples fits exactly.
  function automatic int acc_w(input int log2n);
    return MAG_W + log2n;
  endfunction
endpackage

// File: rtl/mag_pkhold.sv
// Peak hold/decay register: holds a new peak for HOLD blocks, then decays by pk>>DECAY_SHIFT per block.
module mag_pkhold
  import mag_pkg::*;
#(
  parameter int HOLD        = 4,
  parameter int DECAY_SHIFT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [MAG_W-1:0] bp,
  input  logic             term,
  output logic [MAG_W-1:0] pk
);
  logic [3:0]       hold;
  logic [MAG_W-1:0] d, dec, nxt;

  always_comb begin
    d = pk >> DECAY_SHIFT;
    // Minimum step of 1 so a small peak still drains to zero.
    if (pk != '0 && d == '0) d = MAG_W'(1);
    dec = pk - d;
    nxt = (bp > dec) ? bp : dec;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pk   <= '0;
      hold <= '0;
    end else if (term) begin
      if (bp >= pk) begin
        pk   <= bp;
        hold <= 4'(HOLD);
      end else if (hold != '0) begin
        hold <= hold - 4'd1;
      end else begin
        pk <= nxt;
      end
    end
  end
endmodule

// File: rtl/mag_meter.sv
// Block-average / block-peak meter over 2^LOG2N magnitude samples.
// Optional peak hold/decay enabled by defining MAG_METER_PEAK_HOLD_EN.
module mag_meter
  import mag_pkg::*;
#(
  parameter int LOG2N       = 8,
  parameter int HOLD        = 4,
  parameter int DECAY_SHIFT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [MAG_W-1:0] m,
  input  logic             iv,
  output logic [MAG_W-1:0] avg,
  output logic [MAG_W-1:0] pk,
  output logic             ov
);
  localparam int AW = acc_w(LOG2N);

  logic [AW-1:0]    acc, sum;
  logic [LOG2N-1:0] cnt;
  logic [MAG_W-1:0] blkpk, bp;
  logic             term;

  always_comb begin
    sum  = acc + AW'(m);
    bp   = (m > blkpk) ? m : blkpk;
    term = iv && (cnt == '1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      cnt   <= '0;
      blkpk <= '0;
      avg   <= '0;
      ov    <= 1'b0;
    end else begin
      ov <= term;
      if (iv) begin
        cnt <= cnt + 1'b1;
        if (term) begin
          acc   <= '0;
          blkpk <= '0;
          avg   <= sum[AW-1:LOG2N];
        end else begin
          acc   <= sum;
          blkpk <= bp;
        end
      end
    end
  end

`ifdef MAG_METER_PEAK_HOLD_EN
  mag_pkhold #(.HOLD(HOLD), .DECAY_SHIFT(DECAY_SHIFT)) u_pkhold (
    .clk (clk),
    .rst (rst),
    .bp  (bp),
    .term(term),
    .pk  (pk)
  );
`else
  always_ff @(posedge clk) begin
    if (rst)       pk <= '0;
    else if (term) pk <= bp;
  end
`endif
endmodule

// File: tb/tb_mag_meter.sv
// Scoreboard bench for mag_meter: stimulus queues expected block results, a monitor checks each ov.
module tb_mag_meter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] m   = '0;
  logic        iv  = 1'b0;
  logic [11:0] avg, pk;
  logic        ov;

  mag_meter dut (
    .clk(clk), .rst(rst), .m(m), .iv(iv),
    .avg(avg), .pk(pk), .ov(ov)
  );

  always #5 clk = ~clk;

  typedef struct {
    int avg;
    int pk;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   tests  = 0;
  int   fails  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every ov must match the oldest queued block result, one clk after its terminal sample.
  always @(negedge clk) begin
    if (ov) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_ov: ov at cyc %0d avg=%0d pk=%0d, nothing expected", cyc, avg, pk);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (avg != e.avg || pk != e.pk || cyc != e.cyc) begin
          fails++;
          $display("FAIL block_result: got avg=%0d pk=%0d cyc=%0d expected avg=%0d pk=%0d cyc=%0d",
                   avg, pk, cyc, e.avg, e.pk, e.cyc);
        end
      end
    end
  end

  // One sample, followed by gap idle clocks; last=1 queues the block result.
  task automatic smp(input int v, input int gap, input bit last, input int eavg, input int epk);
    exp_t e;
    @(negedge clk);
    m  = 12'(v);
    iv = 1'b1;
    if (last) begin
      e.avg = eavg; e.pk = epk; e.cyc = cyc + 1;
      q.push_back(e);
    end
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      iv = 1'b0;
    end
  endtask

  task automatic blk(input int v, input int eavg, input int epk);
    for (int i = 0; i < 256; i++) smp(v, 0, i == 255, eavg, epk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      iv = 1'b0;
    end
  endtask

  task automatic do_rst();
    @(negedge clk);
    iv  = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int steady_pk;
    int seq[];
    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_avg", int'(avg), 0);
    chk("reset_pk", int'(pk), 0);
    chk("reset_ov", int'(ov), 0);
    rst = 1'b0;

    // Constant block, back-to-back
    blk(100, 100, 100);
    idle(3);

    // Ramp 0..255: sum 32640 -> avg 127
    for (int i = 0; i < 256; i++) smp(i, 0, i == 255, 127, 255);
`ifdef MAG_METER_PEAK_HOLD_EN
    steady_pk = 255;
`else
    steady_pk = 5;
`endif
    blk(5, 5, steady_pk);
    idle(2);

    // Sparse full-scale block; outputs must hold between strobes
    for (int i = 0; i < 256; i++) begin
      smp(4095, 2, i == 255, 4095, 4095);
      if (i == 128) begin
        chk("steady_avg", int'(avg), 5);
        chk("steady_pk", int'(pk), steady_pk);
      end
    end
    idle(2);
    chk("hold_after_avg", int'(avg), 4095);
    chk("hold_after_pk", int'(pk), 4095);

    // Mid-block reset discards the partial block
    for (int i = 0; i < 100; i++) smp(4000, 0, 1'b0, 0, 0);
    do_rst();
    chk("midrst_avg", int'(avg), 0);
    blk(10, 10, 10);
    idle(2);

    // Reset coincident with terminal sample: no ov, outputs cleared
    for (int i = 0; i < 255; i++) smp(7, 0, 1'b0, 0, 0);
    @(negedge clk);
    m = 12'd7; iv = 1'b1; rst = 1'b1;
    @(negedge clk);
    iv = 1'b0; rst = 1'b0;
    chk("rst_term_avg", int'(avg), 0);
    chk("rst_term_pk", int'(pk), 0);
    chk("rst_term_ov", int'(ov), 0);
    idle(3);

`ifdef MAG_METER_PEAK_HOLD_EN
    // Hold 4 blocks then decay by pk>>3; a 3000 peak during decay re-arms
    do_rst();
    blk(4000, 4000, 4000);
    seq = '{4000, 4000, 4000, 4000, 3500, 3063, 2681};
    foreach (seq[i]) blk(0, 0, seq[i]);
    blk(3000, 3000, 3000);
    blk(0, 0, 3000);
    // Small peak drains by at least 1 per block
    do_rst();
    blk(5, 5, 5);
    seq = '{5, 5, 5, 5, 4, 3, 2, 1, 0, 0};
    foreach (seq[i]) blk(0, 0, seq[i]);
    idle(2);
`else
    seq = '{0};
    steady_pk = seq[0];
`endif

    idle(4);
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Safety net against a stuck run
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, q=%0d", q.size());
    $fatal(1, "timeout");
  end
endmodule
